// File: rtl/phy_tx_lane_scheduler.sv
// Purpose: round-robin scheduler sharing one serial lane between two byte requesters, with comma preamble/idle fill.
// Latency: a byte is sampled on a load edge (every 8th cycle) and its MSB appears on data_out right after that edge.
// Backpressure: requesters hold valid+data until their pop pulse; valid is sampled only at byte boundaries.
// Optional feature: define PHY_TX_RESYNC_EN to force one comma after every RESYNC_PERIOD back-to-back data bytes.
module phy_tx_lane_scheduler #(
  parameter int unsigned SYNC_COMMAS   = 4,
  parameter logic [7:0]  COMMA         = 8'hBC,
  parameter int unsigned RESYNC_PERIOD = 16
) (
  input  logic       clk_32f,
  input  logic       default_values,
  input  logic [7:0] data_in_0,
  input  logic       valid_in_0,
  output logic       pop_0,
  input  logic [7:0] data_in_1,
  input  logic       valid_in_1,
  output logic       pop_1,
  output logic       data_out,
  output logic       byte_start,
  output logic       sync_done,
  output logic       sending_data,
  output logic       lane_id
);

  // Wide enough to hold the value SYNC_COMMAS itself (the count that ends the preamble).
  localparam int CW = (SYNC_COMMAS < 1) ? 1 : $clog2(SYNC_COMMAS + 1);

  typedef enum logic [0:0] {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // A zero resync period would force commas forever and starve both lanes.
  if (RESYNC_PERIOD == 0) begin : g_bad_resync_period
    $error("phy_tx_lane_scheduler: RESYNC_PERIOD must be at least 1");
  end

  state_t        state;
  state_t        state_nxt;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_nxt;
  logic [7:0]    shreg;
  logic [CW-1:0] comma_cnt;
  logic [CW-1:0] comma_cnt_nxt;
  logic          last_lane;

  logic          is_load;
  logic          run_sel;
  logic          take_data;
  logic          pick_lane;
  logic [7:0]    load_byte;
  logic          force_comma;

`ifdef PHY_TX_RESYNC_EN
  localparam int RW = (RESYNC_PERIOD < 1) ? 1 : $clog2(RESYNC_PERIOD + 1);

  logic [RW-1:0] data_run;

  // Once RESYNC_PERIOD data bytes have gone out back to back, the next slot carries a comma.
  assign force_comma = (data_run == RW'(RESYNC_PERIOD));

  // Count consecutive data bytes; any comma (preamble, idle or forced) restarts the run.
  always_ff @(posedge clk_32f) begin
    if (default_values) begin
      data_run <= '0;
    end else if (is_load) begin
      data_run <= take_data ? data_run + RW'(1) : '0;
    end
  end
`else
  assign force_comma = 1'b0;
`endif

  // State register: the FSM only advances on load edges (gated in the next-state logic).
  always_ff @(posedge clk_32f) begin
    if (default_values) begin
      state <= ST_SYNC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and byte selection for the coming load edge.
  always_comb begin
    is_load       = (bit_cnt == 3'd7);
    bit_nxt       = bit_cnt + 3'd1;
    state_nxt     = state;
    comma_cnt_nxt = comma_cnt;
    run_sel       = 1'b0;
    take_data     = 1'b0;
    pick_lane     = last_lane;
    load_byte     = COMMA;

    if (is_load) begin
      case (state)
        ST_SYNC: begin
          // The load that sees the full preamble count already uses run-mode selection.
          if (comma_cnt == CW'(SYNC_COMMAS)) begin
            state_nxt = ST_RUN;
            run_sel   = 1'b1;
          end else begin
            comma_cnt_nxt = comma_cnt + CW'(1);
          end
        end
        ST_RUN: begin
          run_sel = 1'b1;
        end
        default: begin
          state_nxt = ST_SYNC;
        end
      endcase
    end

    // Round robin: on a tie the lane that did not win last time goes; a lone requester always wins.
    if (run_sel && !force_comma && (valid_in_0 || valid_in_1)) begin
      take_data = 1'b1;
      if (valid_in_0 && valid_in_1) begin
        pick_lane = ~last_lane;
      end else begin
        pick_lane = valid_in_1;
      end
      load_byte = pick_lane ? data_in_1 : data_in_0;
    end
  end

  // Datapath: capture a byte on load edges, otherwise walk the held byte out MSB first.
  always_ff @(posedge clk_32f) begin
    if (default_values) begin
      shreg        <= 8'h00;
      data_out     <= 1'b0;
      byte_start   <= 1'b0;
      bit_cnt      <= 3'd7;
      comma_cnt    <= '0;
      sync_done    <= 1'b0;
      pop_0        <= 1'b0;
      pop_1        <= 1'b0;
      sending_data <= 1'b0;
      lane_id      <= 1'b0;
      last_lane    <= 1'b1;
    end else if (is_load) begin
      shreg        <= load_byte;
      data_out     <= load_byte[7];
      byte_start   <= 1'b1;
      bit_cnt      <= 3'd0;
      comma_cnt    <= comma_cnt_nxt;
      sync_done    <= sync_done | (state_nxt == ST_RUN);
      pop_0        <= take_data & ~pick_lane;
      pop_1        <= take_data & pick_lane;
      sending_data <= take_data;
      if (take_data) begin
        lane_id   <= pick_lane;
        last_lane <= pick_lane;
      end
    end else begin
      data_out   <= shreg[3'd7 - bit_nxt];
      byte_start <= 1'b0;
      bit_cnt    <= bit_nxt;
      pop_0      <= 1'b0;
      pop_1      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_phy_tx_lane_scheduler.sv
// Bench for phy_tx_lane_scheduler: byte-slot reference model feeding a scoreboard queue,
// with an independent monitor that deserializes data_out and checks each byte and its side signals.
// Directed phases follow the block's test plan, then a randomized phase with occasional resets.
module tb_phy_tx_lane_scheduler;

  localparam int         SYNC_N  = 4;
  localparam logic [7:0] COMMA_B = 8'hBC;
`ifdef PHY_TX_RESYNC_EN
  localparam int TB_RP = 2;
`else
  localparam int TB_RP = 16;
`endif

  logic       clk_32f = 1'b0;
  logic       default_values = 1'b1;
  logic [7:0] data_in_0 = 8'h00;
  logic       valid_in_0 = 1'b0;
  logic       pop_0;
  logic [7:0] data_in_1 = 8'h00;
  logic       valid_in_1 = 1'b0;
  logic       pop_1;
  logic       data_out;
  logic       byte_start;
  logic       sync_done;
  logic       sending_data;
  logic       lane_id;

  phy_tx_lane_scheduler #(
    .SYNC_COMMAS   (SYNC_N),
    .COMMA         (COMMA_B),
    .RESYNC_PERIOD (TB_RP)
  ) dut (
    .clk_32f        (clk_32f),
    .default_values (default_values),
    .data_in_0      (data_in_0),
    .valid_in_0     (valid_in_0),
    .pop_0          (pop_0),
    .data_in_1      (data_in_1),
    .valid_in_1     (valid_in_1),
    .pop_1          (pop_1),
    .data_out       (data_out),
    .byte_start     (byte_start),
    .sync_done      (sync_done),
    .sending_data   (sending_data),
    .lane_id        (lane_id)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    logic [7:0] b;
    logic       is_data;
    logic       lane;
    logic       sync;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int bytes_done = 0;

  // Reference model state: edges since reset release, last granted lane, data run length.
  int   edge_n = 0;
  logic m_last = 1'b1;
  int   m_run  = 0;
  logic pend0  = 1'b0;
  logic pend1  = 1'b0;
  logic rnd0   = 1'b0;
  logic rnd1   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Decide the byte for one slot from the rules: preamble commas, forced resync comma,
  // round robin between valid lanes, idle comma.
  task automatic model_load();
    exp_t e;
    int   k;
    logic forced;
    k         = (edge_n - 1) / 8;
    e.b       = COMMA_B;
    e.is_data = 1'b0;
    e.lane    = 1'b0;
    e.sync    = (k >= SYNC_N);
    forced    = 1'b0;
    if (k >= SYNC_N) begin
`ifdef PHY_TX_RESYNC_EN
      forced = (m_run == TB_RP);
`endif
      if (!forced && (valid_in_0 || valid_in_1)) begin
        e.is_data = 1'b1;
        e.lane    = (valid_in_0 && valid_in_1) ? ~m_last : valid_in_1;
        e.b       = e.lane ? data_in_1 : data_in_0;
        m_last    = e.lane;
        m_run     = m_run + 1;
        if (e.lane) pend1 = 1'b1;
        else        pend0 = 1'b1;
      end else begin
        m_run = 0;
      end
    end
    exp_q.push_back(e);
  endtask

  // One clock cycle, entered and left at a negedge with inputs stable for the coming posedge.
  task automatic step();
    if (default_values) begin
      edge_n = 0;
      m_last = 1'b1;
      m_run  = 0;
      pend0  = 1'b0;
      pend1  = 1'b0;
    end else begin
      edge_n = edge_n + 1;
      if (((edge_n - 1) % 8) == 0) model_load();
    end
    @(posedge clk_32f);
    @(negedge clk_32f);
    // Requesters react to a grant by presenting their next byte.
    if (pend0) begin
      pend0 = 1'b0;
      if (rnd0) begin
        data_in_0  = 8'($urandom);
        valid_in_0 = ($urandom_range(0, 3) != 0);
      end
    end
    if (pend1) begin
      pend1 = 1'b0;
      if (rnd1) begin
        data_in_1  = 8'($urandom);
        valid_in_1 = ($urandom_range(0, 3) != 0);
      end
    end
    // Random mid-byte valid changes, including drops before a boundary.
    if (rnd0 && $urandom_range(0, 11) == 0) begin
      valid_in_0 = ~valid_in_0;
      if (valid_in_0) data_in_0 = 8'($urandom);
    end
    if (rnd1 && $urandom_range(0, 11) == 0) begin
      valid_in_1 = ~valid_in_1;
      if (valid_in_1) data_in_1 = 8'($urandom);
    end
  endtask

  task automatic do_reset(input int n);
    default_values = 1'b1;
    repeat (n) step();
    default_values = 1'b0;
  endtask

  // Monitor: checks reset values, then deserializes each byte and compares it with the scoreboard.
  initial begin
    int         bitn;
    int         gap;
    logic [7:0] sh;
    logic       quiet;
    exp_t       e;
    bitn  = -1;
    gap   = 0;
    sh    = 8'h00;
    quiet = 1'b1;
    forever begin
      @(posedge clk_32f);
      #1;
      if (default_values) begin
        exp_q.delete();
        bitn = -1;
        gap  = 0;
        chk("rst_data_out", data_out, 0);
        chk("rst_byte_start", byte_start, 0);
        chk("rst_sync_done", sync_done, 0);
        chk("rst_pops", {pop_1, pop_0}, 0);
        chk("rst_sending_data", sending_data, 0);
        chk("rst_lane_id", lane_id, 0);
      end else if (byte_start) begin
        if (bitn >= 0) chk("byte_length", bitn + 1, 8);
        gap = 0;
        if (exp_q.size() == 0) begin
          chk("byte_expected", 0, 1);
          bitn = -1;
        end else begin
          e     = exp_q.pop_front();
          bitn  = 0;
          sh    = {7'b0, data_out};
          quiet = 1'b1;
          chk("pop_0", pop_0, e.is_data && !e.lane);
          chk("pop_1", pop_1, e.is_data && e.lane);
          chk("sending_data", sending_data, e.is_data);
          chk("sync_done", sync_done, e.sync);
          if (e.is_data) chk("lane_id", lane_id, e.lane);
        end
      end else begin
        gap++;
        if (gap >= 8) begin
          chk("byte_start_period", gap, 7);
          gap = 0;
        end
        if (bitn >= 0) begin
          sh   = {sh[6:0], data_out};
          bitn = bitn + 1;
          if (pop_0 || pop_1) quiet = 1'b0;
          if (bitn == 7) begin
            chk("byte_value", sh, e.b);
            chk("no_pop_mid_byte", quiet, 1);
            bytes_done++;
            bitn = -1;
          end
        end
      end
    end
  end

  // Stimulus: directed phases, then randomized traffic with occasional resets.
  initial begin
    @(negedge clk_32f);
    repeat (4) step();

    // Idle after reset: preamble then idle commas.
    default_values = 1'b0;
    repeat (48) step();

    // Lane 0 holds 8'hA5 from release.
    default_values = 1'b1;
    valid_in_0 = 1'b1; data_in_0 = 8'hA5;
    valid_in_1 = 1'b0; data_in_1 = 8'h00;
    do_reset(2);
    repeat (48) step();

    // Both lanes valid continuously: strict alternation.
    valid_in_0 = 1'b1; data_in_0 = 8'h11;
    valid_in_1 = 1'b1; data_in_1 = 8'h22;
    do_reset(2);
    repeat (100) step();

    // Lane 1 raised mid-way through an idle comma.
    valid_in_0 = 1'b0; valid_in_1 = 1'b0;
    do_reset(2);
    repeat (36) step();
    valid_in_1 = 1'b1; data_in_1 = 8'h22;
    repeat (24) step();

    // Reset in the middle of a data byte, then full preamble again.
    valid_in_0 = 1'b1; data_in_0 = 8'hA5; valid_in_1 = 1'b0;
    do_reset(2);
    repeat (36) step();
    do_reset(1);
    repeat (48) step();

    // A data byte equal to the comma value goes out unchanged.
    valid_in_0 = 1'b1; data_in_0 = COMMA_B; valid_in_1 = 1'b0;
    do_reset(2);
    repeat (48) step();

    // Randomized traffic.
    rnd0 = 1'b1;
    rnd1 = 1'b1;
    do_reset(2);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset($urandom_range(1, 3));
      step();
    end

    chk("bytes_checked_enough", (bytes_done >= 400), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/phy_tx_lane_scheduler.md
Name: phy_tx_lane_scheduler

Overview:
Transmit-side scheduler for the PHY serial link, running at clk_32f. Shares one serial lane between two 8-bit byte requesters using round-robin arbitration. Emits a comma (8'hBC) preamble after reset so the far-end serial-to-parallel receiver can lock. Fills idle byte slots with commas and serializes each selected byte MSB first.

Parameters:
SYNC_COMMAS, 4, number of commas sent after reset before any data byte (receiver needs at least 4 commas to go active)
COMMA, 8'hBC, idle/sync byte value
RESYNC_PERIOD, 16, data bytes between forced commas (used only with PHY_TX_RESYNC_EN)

Ports:
clk_32f  input  1  bit clock; all logic on posedge
default_values  input  1  reset; synchronous, active-high
data_in_0  input  8  lane 0 byte
valid_in_0  input  1  lane 0 byte available; held with data until pop_0
pop_0  output  1  one-cycle pulse: lane 0 byte accepted
data_in_1  input  8  lane 1 byte
valid_in_1  input  1  lane 1 byte available
pop_1  output  1  one-cycle pulse: lane 1 byte accepted
data_out  output  1  serial bit stream, MSB first
byte_start  output  1  high in the cycle data_out carries bit 7 of a byte
sync_done  output  1  preamble complete; data scheduling enabled
sending_data  output  1  current byte is lane data, not comma
lane_id  output  1  source lane of current data byte (valid when sending_data=1)

Behaviour:
- Clock and reset: one clock, clk_32f. default_values is synchronous and active-high; sampled only on posedge clk_32f.
- Reset values: data_out=0, byte_start=0, pop_0=pop_1=0, sync_done=0, sending_data=0, lane_id=0, state=SYNC, bit_cnt=7, comma_cnt=0, last_lane=1 (lane 0 wins the first tie).
- All outputs are registered.
- Byte boundary is the edge where bit_cnt==7 (the "load edge"). On it:
  - next byte captured into the shift register;
  - data_out <= byte[7]; byte_start <= 1; bit_cnt <= 0.
- Other edges: bit_cnt+1; data_out <= byte[7-bit_cnt_next]; byte_start <= 0.
- Each byte occupies exactly 8 cycles. The first load edge is the first edge with default_values=0.
- FSM SYNC:
  - every load selects COMMA; comma_cnt+1;
  - at the load edge where comma_cnt==SYNC_COMMAS: go to RUN, sync_done <= 1, and that load uses RUN selection.
  - With SYNC_COMMAS=4, the first possible data byte loads at edge 33 after reset release (commas at edges 1, 9, 17, 25).
- FSM RUN, selection at each load edge:
  - both valid: pick !last_lane;
  - one valid: pick it;
  - none: COMMA.
  - Data pick: pop_<lane> <= 1 for exactly that cycle, sending_data <= 1, lane_id <= lane, last_lane <= lane.
  - Comma pick: sending_data <= 0, pops 0, last_lane unchanged.
- Valid handshake:
  - valid/data are sampled only at load edges; valid rising mid-byte waits for the next boundary;
  - requester advances its data on the cycle after seeing pop. The next sample is 8 edges later, so no double-pop.
- valid dropped before a load edge: the byte is not taken and no pop is issued.
- Data bytes equal to COMMA are sent unmodified; avoiding them is an upper-layer responsibility.
- sync_done stays 1 until reset.
- Reset mid-operation: in-flight byte discarded; no pop issued that cycle; all registers return to reset values; preamble restarts in full.

Optional Feature:
Macro PHY_TX_RESYNC_EN.
- Defined: a data-byte counter increments on each data load. When it reaches RESYNC_PERIOD, the next load edge sends one COMMA regardless of valid inputs, with no pop. The counter then clears. Idle commas also clear it.
- Undefined: counter logic absent; commas appear only during the preamble and idle slots.

Test Plan:
1. Reset 4 cycles then release, both valid=0 -> data_out repeats 1,0,1,1,1,1,0,0; byte_start at edges 1,9,17,25,33...; sync_done rises at edge 33; pops never asserted.
2. valid_in_0=1, data_in_0=8'hA5 from reset release -> pop_0 pulse at edge 33 only; data_out 1,0,1,0,0,1,0,1 over edges 33-40; sending_data=1, lane_id=0.
3. Both lanes valid continuously (lane0 8'h11, lane1 8'h22) -> lane order 0,1,0,1; each pop pulses once per 16 cycles; never both in one cycle.
4. valid_in_1 raised at bit_cnt=3 of an idle comma -> comma completes intact; pop_1 and 8'h22 at the next load edge.
5. default_values asserted at bit 3 of a data byte -> next cycle data_out=0, sync_done=0, no pop; after release, 4 full commas precede any data.
6. PHY_TX_RESYNC_EN defined, RESYNC_PERIOD=2, lane 0 always valid -> byte sequence D,D,C,D,D,C after sync; no pop on the forced-comma slots.
